serial_adder_n: RTL and testbench
=================================

SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-003 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port start: input, 1 bit, request to begin an operation; sampled only in IDLE.
REQ-006 Port sub: input, 1 bit, mode select (0 = a+b+cin, 1 = a-b); sampled with start.
REQ-007 Port a: input, WIDTH bits, operand A; sampled with start.
REQ-008 Port b: input, WIDTH bits, operand B; sampled with start.
REQ-009 Port cin: input, 1 bit, carry-in for add mode; sampled with start and ignored when sub=1.
REQ-010 Port busy: output, 1 bit, high while an operation is in progress.
REQ-011 Port done: output, 1 bit, one-cycle pulse when a result is valid.
REQ-012 Port sum: output, WIDTH bits, result word.
REQ-013 Port cout: output, 1 bit, final carry-out; in sub mode 0 = borrow, 1 = no borrow.
REQ-014 Port ovf: output, 1 bit, signed two's-complement overflow.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL capture a into an A shift register and either b (sub=0) or ~b (sub=1) into a B shift register.
REQ-017 On the same start edge the carry flop SHALL be loaded with cin (sub=0) or 1 (sub=1), the bit counter SHALL clear to 0, and the FSM SHALL go to RUN.
REQ-018 In RUN, each cycle SHALL add one bit position, LSB first, using one full-adder cell on A[0], B[0] and the carry flop.
REQ-019 In each RUN cycle the sum bit SHALL shift into the result register MSB-ward, A and B SHALL shift right by one, and the carry flop SHALL take the cell carry-out.
REQ-020 RUN SHALL last exactly WIDTH cycles; when counter = WIDTH-1 the FSM SHALL go to DONE.
REQ-021 In the final RUN cycle the carry into the MSB SHALL be registered so that ovf = carry_in_msb XOR carry_out.
REQ-022 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE unconditionally.
REQ-023 Latency: done SHALL assert WIDTH+1 cycles after the start-accept edge; the next start is accepted no earlier than the cycle after DONE.
REQ-024 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-025 sum, cout and ovf SHALL update only on the edge entering DONE and hold their values until the next DONE entry; they are never exposed mid-computation.
REQ-026 A start asserted while busy=1 SHALL be ignored, not queued.
REQ-027 Changes on a, b, sub or cin while busy=1 SHALL have no effect on the result.
REQ-028 WIDTH=1 SHALL work: one RUN cycle, and ovf = cin_msb XOR cout.
REQ-029 The counter SHALL be $clog2(WIDTH)+1 bits wide so it cannot wrap before the terminal compare.

Reset
REQ-030 rst=1 SHALL force the FSM to IDLE and set busy, done, sum, cout, ovf, the carry flop, the counter and the shift registers to 0.
REQ-031 A reset asserted mid-RUN SHALL abort the operation with no done pulse; sum keeps its reset value of 0.
REQ-032 If rst and start are both 1 in the same cycle, rst SHALL take precedence and start SHALL be dropped.

Structure
REQ-033 State encodings (IDLE=0, RUN=1, DONE=2) and the WIDTH default SHALL live in shared package serial_adder_pkg.
REQ-034 The one-bit full-adder SHALL be a separate combinational sub-module fa_cell (a, b, cin -> s, co), instantiated once.
REQ-035 The top level SHALL hold the FSM, counter, shift registers and output registers only.

Verification (WIDTH=8)
REQ-036 Add: a=0x0F, b=0x01, cin=0, sub=0 -> done at cycle 9 after the start edge; sum=0x10, cout=0, ovf=0.
REQ-037 Carry wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-038 Overflow: a=0x7F, b=0x01 add -> sum=0x80, ovf=1. Then a=0x80, b=0xFF add -> sum=0x7F, cout=1, ovf=1.
REQ-039 Subtract: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0 (cin ignored). Then a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-040 Handshake: start held high continuously -> exactly one done per WIDTH+2 cycles; a/b changed during RUN do not alter the result.
REQ-041 Reset mid-op: rst pulsed at RUN cycle 4 -> busy=0 next cycle, no done, sum=0; the following start computes correctly.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit combinational full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial add/subtract, LSB first, one bit per cycle
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // One extra bit so the counter never wraps before the terminal compare.
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is in place.
    assign res_nxt = WIDTH'({fa_s, res_sr} >> 1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        // carry still holds the carry into the MSB here.
                        sum  <= res_nxt;
                        cout <= fa_co;
                        ovf  <= carry ^ fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed self-checking bench for serial_adder_n
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start1;
    logic       sub1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;

    int checks = 0;
    int errors = 0;
    int ndone;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder_n #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic icin, input logic isub,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
        int         lat;
        logic [7:0] prev;
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        prev = sum;
        @(negedge clk);
        // Operands scrambled while busy must not leak into the result.
        start = 1'b0; a = ~ia; b = ~ib; cin = ~icin; sub = ~isub;
        lat = 1;
        while (!done && lat < 30) begin
            if (lat == 4) begin
                check({tag, "_hold"}, 32'(sum), 32'(prev));
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        @(negedge clk);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic op1(input string tag, input logic ia, input logic ib, input logic icin,
                       input logic esum, input logic ecout, input logic eovf);
        int lat;
        @(negedge clk);
        a1 = ia; b1 = ib; cin1 = icin; sub1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ia; b1 = ~ib;
        lat = 1;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_sum"}, 32'(sum1), 32'(esum));
        check({tag, "_cout"}, 32'(cout1), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf1), 32'(eovf));
        @(negedge clk);
        check({tag, "_idle"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_80_ff", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);

        // start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 8'hFF; b = 8'hFF;
            end
            if (i == 9) begin
                a = 8'h12; b = 8'h34;
            end
            if (done) begin
                ndone++;
                check("hs_sum", 32'(sum), 32'h46);
                check("hs_pos", 32'(i), 32'(10 * ndone - 1));
            end
        end
        start = 1'b0;
        check("hs_count", 32'(ndone), 32'd3);

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        op8("after_abort", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

        // reset beats a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start_busy2", 32'(busy), 32'd0);
        check("rst_start_sum", 32'(sum), 32'd0);

        op1("w1_1_1_c", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        op1("w1_1_0_c", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        op1("w1_0_0_c", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
